// File: rtl/piso_param.sv
// Parametrised parallel-in/serial-out shifter with ready/valid framing,
// last-bit marker, stall, bubble-free reload and a sticky overrun flag.
module piso_param #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i,
   input  logic             l,
   input  logic             en,
   output logic             ready,
   output logic             o,
   output logic             o_valid,
   output logic             last,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [CW-1:0]    cnt;
   logic             at_end;
   logic             take;
   logic             head;

   assign at_end = (cnt == CNT_MAX);

   // ready never looks at l, so a producer may derive l from ready
   assign ready = !rst && ((state == IDLE) || (en && at_end));
   assign take  = l && ready;

   assign head = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

   assign shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg[WIDTH-1:1]};

   assign o_valid = (state == SHIFT);
   assign o       = o_valid && head;
   assign last    = o_valid && at_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         if (l && !ready) begin
            err <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (take) begin
                  shreg <= i;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (en) begin
                  if (!at_end) begin
                     shreg <= shreg_nxt;
                     cnt   <= cnt + 1'b1;
                  end else if (l) begin
                     shreg <= i;
                     cnt   <= '0;
                  end else begin
                     shreg <= '0;
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_param.sv
// Bench for piso_param: word tables feed a bit scoreboard per instance,
// plus hand-built sequences for reload, stall, overrun and reset.
module tb_piso_param;

   typedef struct packed {
      logic o;
      logic last;
   } bit_t;

   typedef struct {
      logic [7:0] word;
      logic [7:0] seq;
   } vec8_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       l   = 1'b0;
   logic       l4  = 1'b0;
   logic       en  = 1'b1;
   logic [7:0] i8  = '0;
   logic [3:0] i4  = '0;

   logic rdy8, o8, v8, last8, err8;
   logic rdy4m, o4m, v4m, last4m, err4m;
   logic rdy4l, o4l, v4l, last4l, err4l;

   bit_t q8[$];
   bit_t q4m[$];
   bit_t q4l[$];

   int tests = 0;
   int fails = 0;
   bit mon_on = 1'b0;

   always #5 clk = ~clk;

   piso_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
      .clk(clk), .rst(rst), .i(i8), .l(l), .en(en),
      .ready(rdy8), .o(o8), .o_valid(v8), .last(last8), .err(err8)
   );

   piso_param #(.WIDTH(4), .MSB_FIRST(1'b1)) u4m (
      .clk(clk), .rst(rst), .i(i4), .l(l4), .en(en),
      .ready(rdy4m), .o(o4m), .o_valid(v4m), .last(last4m), .err(err4m)
   );

   piso_param #(.WIDTH(4), .MSB_FIRST(1'b0)) u4l (
      .clk(clk), .rst(rst), .i(i4), .l(l4), .en(en),
      .ready(rdy4l), .o(o4l), .o_valid(v4l), .last(last4l), .err(err4l)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // The bit on o is consumed at the next edge only when en is high.
   always @(negedge clk) begin
      if (mon_on) begin
         if (v8) begin
            chk("u8 bit expected", q8.size() != 0, 1);
            if (q8.size() != 0) begin
               chk("u8 o", o8, q8[0].o);
               chk("u8 last", last8, q8[0].last);
               if (en) void'(q8.pop_front());
            end
         end else begin
            chk("u8 idle o/last", {o8, last8}, 0);
         end
         if (v4m) begin
            chk("u4m bit expected", q4m.size() != 0, 1);
            if (q4m.size() != 0) begin
               chk("u4m o", o4m, q4m[0].o);
               chk("u4m last", last4m, q4m[0].last);
               if (en) void'(q4m.pop_front());
            end
         end
         if (v4l) begin
            chk("u4l bit expected", q4l.size() != 0, 1);
            if (q4l.size() != 0) begin
               chk("u4l o", o4l, q4l[0].o);
               chk("u4l last", last4l, q4l[0].last);
               if (en) void'(q4l.pop_front());
            end
         end
      end
   end

   task automatic push8(input logic [7:0] seq);
      bit_t b;
      for (int k = 0; k < 8; k++) begin
         b.o    = seq[7-k];
         b.last = (k == 7);
         q8.push_back(b);
      end
   endtask

   task automatic push4(input logic [3:0] seq, input bit lsb);
      bit_t b;
      for (int k = 0; k < 4; k++) begin
         b.o    = seq[3-k];
         b.last = (k == 3);
         if (lsb) q4l.push_back(b);
         else q4m.push_back(b);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((q8.size() + q4m.size() + q4l.size()) != 0 && n < 60) begin
         cyc();
         n++;
      end
      chk({name, " drained"}, q8.size() + q4m.size() + q4l.size(), 0);
   endtask

   vec8_t tbl[6];

   initial begin
      tbl[0] = '{8'hA5, 8'b10100101};
      tbl[1] = '{8'h3C, 8'b00111100};
      tbl[2] = '{8'hF0, 8'b11110000};
      tbl[3] = '{8'h01, 8'b00000001};
      tbl[4] = '{8'h80, 8'b10000000};
      tbl[5] = '{8'h6E, 8'b01101110};

      rst = 1'b1;
      cyc();
      cyc();
      chk("reset o/valid/last/err", {o8, v8, last8, err8}, 0);
      chk("ready low in reset", rdy8, 0);
      rst = 1'b0;
      #1;
      chk("ready idle", rdy8, 1);
      mon_on = 1'b1;

      // 4-bit instances, both bit orders
      i4 = 4'b1010;
      l4 = 1'b1;
      push4(4'b1010, 1'b0);
      push4(4'b0101, 1'b1);
      cyc();
      l4 = 1'b0;
      chk("u4m valid first cycle", v4m, 1);
      drain("w4");
      chk("u4m idle after word", {v4m, rdy4m}, 2'b01);
      chk("u4l idle after word", {v4l, rdy4l}, 2'b01);

      // table of single words on the 8-bit instance
      for (int t = 0; t < 6; t++) begin
         i8 = tbl[t].word;
         l  = 1'b1;
         push8(tbl[t].seq);
         cyc();
         l  = 1'b0;
         i8 = '0;
         drain("tbl");
         chk("tbl idle ready", {v8, rdy8}, 2'b01);
      end

      // back-to-back reload on the last bit, no bubble
      i8 = 8'hA5;
      l  = 1'b1;
      push8(8'b10100101);
      cyc();
      l = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("b2b valid", v8, 1);
         if (k == 7) begin
            chk("b2b ready on last", rdy8, 1);
            chk("b2b last bit 8", last8, 1);
            i8 = 8'h3C;
            l  = 1'b1;
            push8(8'b00111100);
         end
         cyc();
         l = 1'b0;
      end
      chk("b2b idle after 16", v8, 0);
      chk("b2b no err", err8, 0);

      // stall three cycles on the third bit
      i8 = 8'hF0;
      l  = 1'b1;
      push8(8'b11110000);
      cyc();
      l = 1'b0;
      cyc();
      cyc();
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("stall hold o", {o8, v8}, 2'b11);
         chk("stall ready low", rdy8, 0);
      end
      en = 1'b1;
      drain("stall");

      // stalled last bit keeps ready low
      i8 = 8'h01;
      l  = 1'b1;
      push8(8'b00000001);
      cyc();
      l = 1'b0;
      repeat (7) cyc();
      en = 1'b0;
      #1;
      chk("stalled last ready", {last8, rdy8}, 2'b10);
      cyc();
      en = 1'b1;
      drain("stall last");

      // overrun mid-word
      i8 = 8'h5A;
      l  = 1'b1;
      push8(8'b01011010);
      cyc();
      l = 1'b0;
      repeat (3) cyc();
      chk("err before overrun", err8, 0);
      i8 = 8'hFF;
      l  = 1'b1;
      cyc();
      l = 1'b0;
      chk("err set", err8, 1);
      drain("overrun");
      repeat (2) cyc();
      chk("err sticky", err8, 1);
      rst = 1'b1;
      #1;
      chk("ready low during rst", rdy8, 0);
      cyc();
      rst = 1'b0;
      chk("err cleared", err8, 0);

      // reset mid-word, then a clean word
      i8 = 8'hFF;
      l  = 1'b1;
      push8(8'b11111111);
      cyc();
      l = 1'b0;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      q8.delete();
      chk("rst mid o/valid/last", {o8, v8, last8}, 0);
      rst = 1'b0;
      cyc();
      chk("post rst idle", {v8, rdy8}, 2'b01);
      i8 = 8'h81;
      l  = 1'b1;
      push8(8'b10000001);
      cyc();
      l = 1'b0;
      drain("post rst");
      chk("post rst err", err8, 0);

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
